line_clear_seq: RTL and testbench

Sequential, parametrised line-clear engine for the playfield. On `start` it snapshots the per-row full flags and walks them lowest row first. For each full row it issues one shift command, a row index plus a shift mask, over a valid/ready handshake to the board store. It updates its snapshot to reflect the collapse, then repeats until no full rows remain. It also keeps per-pass and running totals of cleared lines for the scoring logic.

---
 rtl/line_clear_seq.sv | 133 +++++++++++++
 tb/tb_line_clear_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_clear_seq.sv
// Line-clear engine: snapshots the full-row flags and issues one shift
// command per full row (lowest first) to the board store.
module line_clear_seq #(
    parameter int ROWS  = 23,
    parameter int IDX_W = 5,
    parameter int TOT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROWS-1:0]   rowfull,
    output logic              busy,
    output logic              shift_valid,
    input  logic              shift_ready,
    output logic [IDX_W-1:0]  shift_row,
    output logic [ROWS-1:0]   rowshift,
    output logic              done,
    output logic [IDX_W:0]    lines_cleared,
    output logic [TOT_W-1:0]  total_lines
);

    localparam int LW = IDX_W + 1;
    localparam logic [ROWS-1:0]  ONE_ROW = ROWS'(1);
    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t            state_q;
    logic [ROWS-1:0]   snap_q;
    logic [ROWS-1:0]   snap_d;
    logic              busy_q;
    logic              valid_q;
    logic              done_q;
    logic [IDX_W-1:0]  row_q;
    logic [ROWS-1:0]   mask_q;
    logic [IDX_W:0]    lines_q;
    logic [TOT_W-1:0]  total_q;
    logic              xfer;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [IDX_W-1:0] lowestIdx(input logic [ROWS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Every bit at or above the lowest set bit; 0 when nothing is set.
    function automatic logic [ROWS-1:0] lowMask(input logic [ROWS-1:0] v);
        logic [ROWS-1:0] lsb;
        lsb = v & (~v + ONE_ROW);
        return (v == '0) ? '0 : ~(lsb - ONE_ROW);
    endfunction

    assign xfer = valid_q && shift_ready;

    // Collapse the snapshot: rows at or above k drop by one, top row empties.
    always_comb begin
        snap_d = snap_q;
        if (xfer) begin
            snap_d = (snap_q & ~mask_q) | ((snap_q >> 1) & mask_q);
        end
    end

    // Outputs are registered alongside the state so they never depend on
    // start or shift_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            snap_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            row_q   <= '0;
            mask_q  <= '0;
            lines_q <= '0;
            total_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ACTIVE;
                        snap_q  <= rowfull;
                        lines_q <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= |rowfull;
                        done_q  <= ~|rowfull;
                        row_q   <= lowestIdx(rowfull);
                        mask_q  <= lowMask(rowfull);
                    end
                end
                ACTIVE: begin
                    if (done_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        valid_q <= 1'b0;
                        row_q   <= '0;
                        mask_q  <= '0;
                    end else if (xfer) begin
                        snap_q  <= snap_d;
                        lines_q <= lines_q + LW'(1);
                        if (total_q != TOT_MAX) total_q <= total_q + TOT_W'(1);
                        valid_q <= |snap_d;
                        done_q  <= ~|snap_d;
                        row_q   <= lowestIdx(snap_d);
                        mask_q  <= lowMask(snap_d);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign shift_valid   = valid_q;
    assign shift_row     = row_q;
    assign rowshift      = mask_q;
    assign done          = done_q;
    assign lines_cleared = lines_q;
    assign total_lines   = total_q;

    a_done_excl: assert property (@(posedge clk) disable iff (rst) !(done && shift_valid));

    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (shift_valid && !shift_ready) |=> (shift_valid && $stable(shift_row) && $stable(rowshift)));

endmodule

// File: tb/tb_line_clear_seq.sv
// Bench for line_clear_seq: a transaction-level model predicts every cycle,
// and directed passes pin literal values from hand calculation.
module tb_line_clear_seq;

    localparam int ROWS  = 23;
    localparam int IDX_W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             shift_ready = 1'b0;
    logic [ROWS-1:0]  rowfull = '0;

    logic             busy, shift_valid, done;
    logic [IDX_W-1:0] shift_row;
    logic [ROWS-1:0]  rowshift;
    logic [IDX_W:0]   lines_cleared;
    logic [15:0]      total_lines;

    logic             busy3, shift_valid3, done3;
    logic [IDX_W-1:0] shift_row3;
    logic [ROWS-1:0]  rowshift3;
    logic [IDX_W:0]   lines_cleared3;
    logic [2:0]       total_lines3;

    line_clear_seq #(.ROWS(ROWS), .IDX_W(IDX_W), .TOT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .rowfull(rowfull),
        .busy(busy), .shift_valid(shift_valid), .shift_ready(shift_ready),
        .shift_row(shift_row), .rowshift(rowshift), .done(done),
        .lines_cleared(lines_cleared), .total_lines(total_lines)
    );

    line_clear_seq #(.ROWS(ROWS), .IDX_W(IDX_W), .TOT_W(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .rowfull(rowfull),
        .busy(busy3), .shift_valid(shift_valid3), .shift_ready(shift_ready),
        .shift_row(shift_row3), .rowshift(rowshift3), .done(done3),
        .lines_cleared(lines_cleared3), .total_lines(total_lines3)
    );

    int checks = 0;
    int failures = 0;
    bit cmpEn = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Pass model: the j-th full row (ascending) is removed at row r_j - j,
    // since each earlier clear has dropped it by one.
    bit   mActive = 1'b0;
    int   mCmds[$];
    int   mLines = 0;
    int   mTotal = 0;
    int   mTotal3 = 0;

    function automatic logic [ROWS-1:0] maskFor(input int k);
        logic [ROWS-1:0] m;
        for (int i = 0; i < ROWS; i++) m[i] = (i >= k);
        return m;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mActive = 1'b0;
            mCmds.delete();
            mLines = 0;
            mTotal = 0;
            mTotal3 = 0;
        end else if (!mActive) begin
            if (start) begin
                int j;
                mActive = 1'b1;
                mLines = 0;
                mCmds.delete();
                j = 0;
                for (int r = 0; r < ROWS; r++) begin
                    if (rowfull[r]) begin
                        mCmds.push_back(r - j);
                        j++;
                    end
                end
            end
        end else if (mCmds.size() == 0) begin
            mActive = 1'b0;
        end else if (shift_ready) begin
            void'(mCmds.pop_front());
            mLines++;
            if (mTotal < 65535) mTotal++;
            if (mTotal3 < 7) mTotal3++;
        end
    end

    always @(negedge clk) begin
        if (cmpEn) begin
            logic            eValid, eDone;
            logic [IDX_W-1:0] eRow;
            logic [ROWS-1:0] eMask;
            eValid = mActive && (mCmds.size() != 0);
            eDone  = mActive && (mCmds.size() == 0);
            eRow   = eValid ? IDX_W'(mCmds[0]) : '0;
            eMask  = eValid ? maskFor(mCmds[0]) : '0;
            checkOutput("busy", 64'(busy), 64'(mActive));
            checkOutput("shift_valid", 64'(shift_valid), 64'(eValid));
            checkOutput("done", 64'(done), 64'(eDone));
            checkOutput("shift_row", 64'(shift_row), 64'(eRow));
            checkOutput("rowshift", 64'(rowshift), 64'(eMask));
            checkOutput("lines_cleared", 64'(lines_cleared), 64'(mLines));
            checkOutput("total_lines", 64'(total_lines), 64'(mTotal));
            checkOutput("t3_busy", 64'(busy3), 64'(mActive));
            checkOutput("t3_shift_valid", 64'(shift_valid3), 64'(eValid));
            checkOutput("t3_done", 64'(done3), 64'(eDone));
            checkOutput("t3_shift_row", 64'(shift_row3), 64'(eRow));
            checkOutput("t3_rowshift", 64'(rowshift3), 64'(eMask));
            checkOutput("t3_lines_cleared", 64'(lines_cleared3), 64'(mLines));
            checkOutput("t3_total_lines", 64'(total_lines3), 64'(mTotal3));
        end
    end

    // Inputs set here are sampled on the following rising edge.
    task automatic applyStimulus(input logic r, input logic s, input logic [ROWS-1:0] rf, input logic rdy);
        @(posedge clk);
        #1;
        rst = r;
        start = s;
        rowfull = rf;
        shift_ready = rdy;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
    endtask

    // Full pass with shift_ready high; bounded wait for done.
    task automatic runPass(input logic [ROWS-1:0] rf);
        bit gotDone;
        gotDone = 1'b0;
        applyStimulus(1'b0, 1'b1, rf, 1'b1);
        for (int c = 0; c < 40 && !gotDone; c++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
            @(negedge clk);
            if (done) gotDone = 1'b1;
        end
        checkOutput("pass_done_seen", 64'(gotDone), 64'(1));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        cmpEn = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_valid", 64'(shift_valid), 64'(0));
        checkOutput("rst_total", 64'(total_lines), 64'(0));

        // Empty board: done on the first active cycle
        applyStimulus(1'b0, 1'b1, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("empty_done", 64'(done), 64'(1));
        checkOutput("empty_busy", 64'(busy), 64'(1));
        checkOutput("empty_lines", 64'(lines_cleared), 64'(0));
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("empty_idle_busy", 64'(busy), 64'(0));
        checkOutput("empty_total", 64'(total_lines), 64'(0));

        // Single bottom row
        applyStimulus(1'b0, 1'b1, 23'h000001, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("one_row", 64'(shift_row), 64'(0));
        checkOutput("one_mask", 64'(rowshift), 64'h7FFFFF);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("one_done", 64'(done), 64'(1));
        checkOutput("one_lines", 64'(lines_cleared), 64'(1));

        // Tetris on rows 3..6
        doReset();
        applyStimulus(1'b0, 1'b1, 23'h000078, 1'b1);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
            @(negedge clk);
            checkOutput("tetris_row", 64'(shift_row), 64'(3));
            checkOutput("tetris_mask", 64'(rowshift), 64'h7FFFF8);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("tetris_done", 64'(done), 64'(1));
        checkOutput("tetris_lines", 64'(lines_cleared), 64'(4));
        checkOutput("tetris_total", 64'(total_lines), 64'(4));

        // Rows 2 and 9 with a three-cycle stall on the first command
        applyStimulus(1'b0, 1'b1, 23'h000204, 1'b0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 1'b0, '0, (c == 3));
            @(negedge clk);
            checkOutput("stall_row", 64'(shift_row), 64'(2));
            checkOutput("stall_valid", 64'(shift_valid), 64'(1));
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("second_row", 64'(shift_row), 64'(8));
        checkOutput("second_mask", 64'(rowshift), 64'h7FFF00);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("stall_done", 64'(done), 64'(1));

        // start and rowfull disturbed mid-pass are ignored
        applyStimulus(1'b0, 1'b1, 23'h000030, 1'b0);
        applyStimulus(1'b0, 1'b1, 23'h7FFFFF, 1'b0);
        @(negedge clk);
        checkOutput("mid_row_a", 64'(shift_row), 64'(4));
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b1, 23'h000001, 1'b0);
        @(negedge clk);
        checkOutput("mid_row_b", 64'(shift_row), 64'(4));
        applyStimulus(1'b0, 1'b0, 23'h000100, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("mid_done", 64'(done), 64'(1));
        checkOutput("mid_lines", 64'(lines_cleared), 64'(2));
        applyStimulus(1'b0, 1'b0, '0, 1'b0);

        // Reset while a command is stalled; handshake on reset cycle uncounted
        applyStimulus(1'b0, 1'b1, 23'h000001, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("abort_valid", 64'(shift_valid), 64'(0));
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_row", 64'(shift_row), 64'(0));
        checkOutput("abort_total", 64'(total_lines), 64'(0));

        // Saturation on the narrow total: 4 + 4 + 1 lines
        runPass(23'h00000F);
        runPass(23'h0000F0);
        runPass(23'h400000);
        checkOutput("sat_total3", 64'(total_lines3), 64'(7));
        checkOutput("sat_total16", 64'(total_lines), 64'(9));
        checkOutput("sat_lines3", 64'(lines_cleared3), 64'(1));

        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        cmpEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
